iter_alu: RTL

Parametrised, multi-cycle successor to the tiny processor's combinational 8-bit ALU. It keeps the same unit/op encoding, adds an iterative divider, and replaces the combinational multiplier with a WIDTH-cycle shift-add engine. All results and flags are registered behind a start/busy/done handshake, so the control FSM can stall on long operations. Single-cycle units still complete in one clock.

---
 rtl/iter_alu.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/iter_alu.sv
// Multi-cycle ALU: single-cycle add/shift/logic plus iterative shift-add multiply
// and restoring divide, all behind a registered start/busy/done handshake.
module iter_alu #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_in,
  input  logic [2:0]       unit_sel_in,
  input  logic             op_sel_in,
  input  logic             mul_seg_sel,
  input  logic [WIDTH-1:0] acc_in,
  input  logic [WIDTH-1:0] src_in,
  output logic             busy_out,
  output logic             done_out,
  output logic [WIDTH-1:0] alu_res_out,
  output logic             zero_out,
  output logic             carry_out
);

  localparam int unsigned CW = SHW + 1;
  localparam int unsigned PW = 2 * WIDTH;

  localparam logic [2:0] U_ADD   = 3'b000;
  localparam logic [2:0] U_MUL   = 3'b001;
  localparam logic [2:0] U_SHIFT = 3'b010;
  localparam logic [2:0] U_PASS  = 3'b011;
  localparam logic [2:0] U_OR    = 3'b100;
  localparam logic [2:0] U_XOR   = 3'b101;
  localparam logic [2:0] U_AND   = 3'b110;
  localparam logic [2:0] U_DIV   = 3'b111;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2:0]       unit_q, unit_d;
  logic             op_q, op_d;
  logic             seg_q, seg_d;
  logic             neg_q, neg_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] acc_mag, src_mag;
  logic             signed_mul;
  logic             iter;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   rem_sh;
  logic             div_ge;
  logic [WIDTH-1:0] div_diff;
  logic [PW-1:0]    prod;
  logic [PW-1:0]    prod_fin;
  logic [WIDTH-1:0] res_c;

  // Datapath helpers and next-state / result selection
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unit_d  = unit_q;
    op_d    = op_q;
    seg_d   = seg_q;
    neg_d   = neg_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    res_d   = res_q;
    zero_d  = zero_q;
    carry_d = carry_q;

    acc_mag    = acc_in[WIDTH-1] ? (~acc_in + WIDTH'(1)) : acc_in;
    src_mag    = src_in[WIDTH-1] ? (~src_in + WIDTH'(1)) : src_in;
    signed_mul = (unit_sel_in == U_MUL) && op_sel_in;
    iter       = (unit_q == U_MUL) || (unit_q == U_DIV);

    add_sum  = {1'b0, a_q} + {1'b0, (op_q ? ~b_q : b_q)} + (WIDTH+1)'(op_q);
    mul_sum  = {1'b0, hi_q} + {1'b0, (lo_q[0] ? a_q : WIDTH'(0))};
    rem_sh   = {hi_q, lo_q[WIDTH-1]};
    div_ge   = rem_sh >= {1'b0, b_q};
    div_diff = rem_sh[WIDTH-1:0] - b_q;
    prod     = {hi_q, lo_q};
    prod_fin = neg_q ? (~prod + PW'(1)) : prod;

    case (unit_q)
      U_ADD:   res_c = add_sum[WIDTH-1:0];
      U_MUL:   res_c = seg_q ? prod_fin[PW-1:WIDTH] : prod_fin[WIDTH-1:0];
      U_SHIFT: res_c = op_q ? (a_q >> b_q[SHW-1:0]) : (a_q << b_q[SHW-1:0]);
      U_PASS:  res_c = b_q;
      U_OR:    res_c = a_q | b_q;
      U_XOR:   res_c = a_q ^ b_q;
      U_AND:   res_c = a_q & b_q;
      U_DIV:   res_c = op_q ? hi_q : lo_q;
      default: res_c = '0;
    endcase

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start_in) begin
          // Multiplier runs on magnitudes; sign is reapplied when the result is taken
          state_d = RUN;
          cnt_d   = '0;
          unit_d  = unit_sel_in;
          op_d    = op_sel_in;
          seg_d   = mul_seg_sel;
          neg_d   = signed_mul && (acc_in[WIDTH-1] ^ src_in[WIDTH-1]);
          a_d     = signed_mul ? acc_mag : acc_in;
          b_d     = src_in;
          hi_d    = '0;
          lo_d    = (unit_sel_in == U_MUL) ? (signed_mul ? src_mag : src_in) : acc_in;
        end
      end
      RUN: begin
        if (iter && (cnt_q != CW'(WIDTH))) begin
          cnt_d = cnt_q + CW'(1);
          if (unit_q == U_MUL) begin
            hi_d = mul_sum[WIDTH:1];
            lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
          end else begin
            hi_d = div_ge ? div_diff : rem_sh[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], div_ge};
          end
        end else begin
          // Final cycle: sign/segment or quotient/remainder selection
          state_d = DONE;
          res_d   = res_c;
          zero_d  = (res_c == '0);
          carry_d = (unit_q == U_ADD) ? add_sum[WIDTH] : 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      unit_q  <= '0;
      op_q    <= 1'b0;
      seg_q   <= 1'b0;
      neg_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      res_q   <= '0;
      zero_q  <= 1'b1;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      unit_q  <= unit_d;
      op_q    <= op_d;
      seg_q   <= seg_d;
      neg_q   <= neg_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy_out    = busy_q;
  assign done_out    = done_q;
  assign alu_res_out = res_q;
  assign zero_out    = zero_q;
  assign carry_out   = carry_q;

endmodule
